ifu_fetch_queue: RTL and testbench
==================================

# ifu_fetch_queue

Parametrised fetch-group queue between the instruction fetch unit and decode. Buffers up to DEPTH fetch groups of GROUP_WORDS 32-bit words each, then unpacks the head group into up to DEC_WIDTH per-instruction lanes per cycle, each with its own PC. Decode may accept only part of the offered lanes. Fetch errors travel as single-lane poisoned instructions, and a flush input empties the queue for redirects.

## Interface
- GROUP_WORDS, 4: 32-bit words per fetch group; power of two, 2..8.
- DEPTH, 4: group entries; power of two, ≥2.
- DEC_WIDTH, 2: output lanes; 1..GROUP_WORDS.
- XLEN, 64: PC width.
- ERR_W, 6: error-type width.
- clk_i  in  1: clock.
- arst_i  in  1: asynchronous active-high reset.
- flush_i  in  1: synchronous clear of all entries.
- enq_instr_i  in  32*GROUP_WORDS: group words; word k is at bits [32k+31:32k].
- enq_grouppc_i  in  XLEN: PC of word 0.
- enq_validword_i  in  GROUP_WORDS: per-word valid mask.
- enq_errtype_i  in  ERR_W: non-zero marks a faulting group.
- enq_valid_i  in  1 / enq_ready_o  out  1: enqueue handshake.
- deq_instr_o  out  32*DEC_WIDTH: lane instructions.
- deq_pc_o  out  XLEN*DEC_WIDTH: lane PCs.
- deq_errtype_o  out  ERR_W*DEC_WIDTH: lane error types.
- deq_valid_o  out  DEC_WIDTH: lane valid; always a contiguous prefix from lane 0.
- deq_take_i  in  clog2(DEC_WIDTH+1): number of lanes accepted this cycle (lanes 0..take-1).
- count_o  out  clog2(DEPTH)+1: occupied entries.
- empty_o  out  1: count_o==0.

## Operation
- Storage: circular buffer of DEPTH entries, each holding {instr, grouppc, remaining mask, errtype}.
- Pointers are clog2(DEPTH) bits wide and wrap naturally. The count register is separate.
- Enqueue fires on enq_valid_i & enq_ready_o.
  - enq_ready_o = (count < DEPTH); full blocks enqueue even if the head pops in the same cycle.
  - A group with validword==0 and errtype==0 is accepted and discarded without being written.
- Normal head (errtype==0):
  - Lanes 0..DEC_WIDTH-1 are assigned to the lowest set bits of the remaining mask, in ascending word order.
  - Lane PC = grouppc + 4*word_index, in XLEN arithmetic with modulo wrap. Lane errtype = 0.
- Faulting head (errtype!=0):
  - Only lane 0 is valid. It carries the lowest valid word, or word 0 if the mask is empty, with that word's PC and the entry's errtype.
  - Taking it pops the whole group.
- Dequeue:
  - Effective take = min(deq_take_i, popcount(deq_valid_o)). Taking more lanes than are valid is a protocol error; an assertion flags it and the RTL clamps.
  - Taken words are cleared from the head's remaining mask.
  - If the mask becomes zero, or a faulting head is taken, the head pops in the same cycle.
- Lanes never span two groups. A head with fewer remaining words than DEC_WIDTH offers fewer lanes.
- Simultaneous enqueue and pop: count is unchanged; both pointers advance.
- flush_i clears count, both pointers and all masks. It overrides enqueue and dequeue in the same cycle; any enqueue in that cycle is lost.

## Timing
- Reset (async assert, sync-safe release): count_o=0, empty_o=1, enq_ready_o=1, deq_valid_o=0. Pointers and masks are zero.
- Enqueue-to-dequeue latency: 1 cycle minimum. There is no bypass; a group written in cycle N appears on deq in cycle N+1.
- Deq outputs are combinational from the head entry and stable within a cycle. deq_take_i is sampled at the clock edge.
- enq_ready_o is combinational from the registered count only, with no path from enq_valid_i or deq_take_i.
- Flush: deq_valid_o=0 and enq_ready_o=1 from the cycle after flush_i is high.
- Reset asserted mid-transfer discards all state immediately.

## Structure
- ifu_pkg holds:
  - fetch_group_t struct {instr, grouppc, validword, errtype};
  - lane_t struct {instr, pc, errtype};
  - the GROUP_WORDS, DEC_WIDTH and ERR_W defaults.
- Sub-module ifu_lane_pick: combinational pick of the first DEC_WIDTH set bits of a GROUP_WORDS mask. It outputs per-lane word indices, lane valids, and the cleared-mask result for a given take count.

## Test plan
- Single group, pc=0x1000, validword=4'b1111, take=2 each cycle: cycle 1 gives PCs 0x1000/0x1004, cycle 2 gives 0x1008/0x100C, then the head pops and empty_o=1.
- validword=4'b1010, take=1: lane 0 shows word 1 at pc+4 with deq_valid_o=2'b11; next cycle word 3 at pc+12 alone with deq_valid_o=2'b01; then pop.
- Fill DEPTH=4 groups with take=0: count_o=4 and enq_ready_o=0. Take the full head while enq_valid_i=1: no enqueue that cycle, enqueue succeeds the next cycle.
- Faulting group, errtype=6'h0C, validword=4'b0110: only lane 0 valid, pc+4, errtype 0x0C; take=1 pops the entire group.
- flush_i asserted together with enq_valid_i and take=2 at count=3: next cycle count_o=0, deq_valid_o=0, and the enqueued group is absent.
- validword=0 with errtype=0: accepted and never presented; grouppc=0xFFFF_FFFF_FFFF_FFF8 with word 3 gives lane PC 0x4 (wrap).

Source files
------------

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and default sizes for the fetch-queue slice.
//   fetch_group_t : one fetch group as produced by the fetch unit.
//   lane_t        : one unpacked instruction lane presented to decode.
//   IFU_*         : default geometry used by ifu_fetch_queue parameters.
package ifu_pkg;

  localparam int IFU_GROUP_WORDS = 4;
  localparam int IFU_DEC_WIDTH   = 2;
  localparam int IFU_ERR_W       = 6;
  localparam int IFU_XLEN        = 64;

  typedef struct packed {
    logic [32*IFU_GROUP_WORDS-1:0] instr;
    logic [IFU_XLEN-1:0]           grouppc;
    logic [IFU_GROUP_WORDS-1:0]    validword;
    logic [IFU_ERR_W-1:0]          errtype;
  } fetch_group_t;

  typedef struct packed {
    logic [31:0]          instr;
    logic [IFU_XLEN-1:0]  pc;
    logic [IFU_ERR_W-1:0] errtype;
  } lane_t;

endpackage

// File: rtl/ifu_lane_pick.sv
// ifu_lane_pick: picks the first DEC_WIDTH set bits of a word mask.
//   mask_i  : remaining-word mask of the head group
//   take_i  : number of lanes consumed this cycle (already clamped)
//   idx_o   : word index feeding each lane (0 when the lane is empty)
//   valid_o : lane valids, contiguous from lane 0
//   mask_o  : mask_i with the taken words cleared
module ifu_lane_pick
  import ifu_pkg::*;
#(
  parameter int GROUP_WORDS = IFU_GROUP_WORDS,
  parameter int DEC_WIDTH   = IFU_DEC_WIDTH,
  parameter int IDX_W       = $clog2(GROUP_WORDS),
  parameter int TAKE_W      = $clog2(DEC_WIDTH + 1)
) (
  input  logic [GROUP_WORDS-1:0] mask_i,
  input  logic [TAKE_W-1:0]      take_i,
  output logic [IDX_W-1:0]       idx_o [DEC_WIDTH],
  output logic [DEC_WIDTH-1:0]   valid_o,
  output logic [GROUP_WORDS-1:0] mask_o
);

  // rank = number of set bits below word w; the word with rank l feeds lane l.
  always_comb begin
    int rank;
    rank    = 0;
    valid_o = '0;
    mask_o  = mask_i;
    for (int l = 0; l < DEC_WIDTH; l++) idx_o[l] = '0;
    for (int w = 0; w < GROUP_WORDS; w++) begin
      if (mask_i[w]) begin
        for (int l = 0; l < DEC_WIDTH; l++) begin
          if (rank == l) begin
            idx_o[l]   = IDX_W'(w);
            valid_o[l] = 1'b1;
          end
        end
        if (rank < int'(take_i)) mask_o[w] = 1'b0;
        rank = rank + 1;
      end
    end
  end

endmodule

// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: circular queue of fetch groups unpacked into decode lanes.
//   clk_i, arst_i              : clock, asynchronous active-high reset
//   flush_i                    : synchronous clear of all entries
//   enq_*                      : fetch group input with valid/ready handshake
//   deq_instr/pc/errtype/valid : per-lane outputs from the head group
//   deq_take_i                 : lanes accepted by decode this cycle
//   count_o, empty_o           : occupancy
module ifu_fetch_queue
  import ifu_pkg::*;
#(
  parameter int GROUP_WORDS = IFU_GROUP_WORDS,
  parameter int DEPTH       = 4,
  parameter int DEC_WIDTH   = IFU_DEC_WIDTH,
  parameter int XLEN        = IFU_XLEN,
  parameter int ERR_W       = IFU_ERR_W,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int CNT_W      = PTR_W + 1,
  localparam int TAKE_W     = $clog2(DEC_WIDTH + 1),
  localparam int IDX_W      = $clog2(GROUP_WORDS)
) (
  input  logic                      clk_i,
  input  logic                      arst_i,
  input  logic                      flush_i,
  input  logic [32*GROUP_WORDS-1:0] enq_instr_i,
  input  logic [XLEN-1:0]           enq_grouppc_i,
  input  logic [GROUP_WORDS-1:0]    enq_validword_i,
  input  logic [ERR_W-1:0]          enq_errtype_i,
  input  logic                      enq_valid_i,
  output logic                      enq_ready_o,
  output logic [32*DEC_WIDTH-1:0]   deq_instr_o,
  output logic [XLEN*DEC_WIDTH-1:0] deq_pc_o,
  output logic [ERR_W*DEC_WIDTH-1:0] deq_errtype_o,
  output logic [DEC_WIDTH-1:0]      deq_valid_o,
  input  logic [TAKE_W-1:0]         deq_take_i,
  output logic [CNT_W-1:0]          count_o,
  output logic                      empty_o
);

  logic [32*GROUP_WORDS-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0]           pc_mem    [DEPTH];
  logic [ERR_W-1:0]          err_mem   [DEPTH];
  logic [GROUP_WORDS-1:0]    mask_mem  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic                      head_valid, head_fault;
  logic [GROUP_WORDS-1:0]    head_mask, mask_after;
  logic [ERR_W-1:0]          head_err;
  logic [XLEN-1:0]           head_pc;
  logic [31:0]               head_words [GROUP_WORDS];
  logic [IDX_W-1:0]          lane_idx [DEC_WIDTH];
  logic [DEC_WIDTH-1:0]      pick_valid, lane_valid;
  logic [TAKE_W-1:0]         n_valid, take_eff;
  logic                      enq_fire, enq_write, pop;

  assign head_valid = (count_reg != '0);
  assign head_mask  = mask_mem[rd_ptr_reg];
  assign head_err   = err_mem[rd_ptr_reg];
  assign head_pc    = pc_mem[rd_ptr_reg];
  assign head_fault = (head_err != '0);

  generate
    for (genvar gi = 0; gi < GROUP_WORDS; gi++) begin : g_words
      assign head_words[gi] = instr_mem[rd_ptr_reg][32*gi +: 32];
    end
  endgenerate

  ifu_lane_pick #(
    .GROUP_WORDS (GROUP_WORDS),
    .DEC_WIDTH   (DEC_WIDTH)
  ) u_pick (
    .mask_i  (head_mask),
    .take_i  (take_eff),
    .idx_o   (lane_idx),
    .valid_o (pick_valid),
    .mask_o  (mask_after)
  );

  // A faulting head offers only lane 0; pick's lane 0 already defaults to word 0.
  always_comb begin
    lane_valid = '0;
    if (head_valid) begin
      if (head_fault) lane_valid[0] = 1'b1;
      else            lane_valid    = pick_valid;
    end
    n_valid = '0;
    for (int l = 0; l < DEC_WIDTH; l++)
      if (lane_valid[l]) n_valid = n_valid + TAKE_W'(1);
  end

  assign take_eff = (deq_take_i > n_valid) ? n_valid : deq_take_i;
  assign pop      = (take_eff != '0) && (head_fault || (mask_after == '0));

  generate
    for (genvar gi = 0; gi < DEC_WIDTH; gi++) begin : g_lanes
      assign deq_instr_o[32*gi +: 32]         = head_words[lane_idx[gi]];
      assign deq_pc_o[XLEN*gi +: XLEN]        = head_pc + XLEN'({lane_idx[gi], 2'b00});
      assign deq_errtype_o[ERR_W*gi +: ERR_W] = head_fault ? head_err : '0;
    end
  endgenerate

  assign deq_valid_o = lane_valid;
  assign count_o     = count_reg;
  assign empty_o     = (count_reg == '0);
  assign enq_ready_o = (count_reg < CNT_W'(DEPTH));
  assign enq_fire    = enq_valid_i & enq_ready_o;
  // Empty, non-faulting groups are acknowledged but never stored.
  assign enq_write   = enq_fire && ((enq_validword_i != '0) || (enq_errtype_i != '0));

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) mask_mem[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) mask_mem[i] <= '0;
    end else begin
      // Head and tail slots differ whenever both are active (0 < count < DEPTH).
      if (take_eff != '0) mask_mem[rd_ptr_reg] <= pop ? '0 : mask_after;
      if (enq_write) begin
        mask_mem[wr_ptr_reg] <= enq_validword_i;
        wr_ptr_reg           <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (enq_write && !pop)      count_reg <= count_reg + CNT_W'(1);
      else if (!enq_write && pop) count_reg <= count_reg - CNT_W'(1);
    end
  end

  // Payload needs no reset: validity is carried by count and mask.
  always_ff @(posedge clk_i) begin
    if (enq_write && !flush_i) begin
      instr_mem[wr_ptr_reg] <= enq_instr_i;
      pc_mem[wr_ptr_reg]    <= enq_grouppc_i;
      err_mem[wr_ptr_reg]   <= enq_errtype_i;
    end
  end

  a_take_le_valid : assert property (@(posedge clk_i) disable iff (arst_i)
    deq_take_i <= n_valid);

endmodule

// File: tb/tb_ifu_fetch_queue.sv
module tb_ifu_fetch_queue;
  import ifu_pkg::*;

  logic          clk_i = 1'b0;
  logic          arst_i, flush_i;
  logic [127:0]  enq_instr_i;
  logic [63:0]   enq_grouppc_i;
  logic [3:0]    enq_validword_i;
  logic [5:0]    enq_errtype_i;
  logic          enq_valid_i, enq_ready_o;
  logic [63:0]   deq_instr_o;
  logic [127:0]  deq_pc_o;
  logic [11:0]   deq_errtype_o;
  logic [1:0]    deq_valid_o;
  logic [1:0]    deq_take_i;
  logic [2:0]    count_o;
  logic          empty_o;

  ifu_fetch_queue dut (
    .clk_i           (clk_i),
    .arst_i          (arst_i),
    .flush_i         (flush_i),
    .enq_instr_i     (enq_instr_i),
    .enq_grouppc_i   (enq_grouppc_i),
    .enq_validword_i (enq_validword_i),
    .enq_errtype_i   (enq_errtype_i),
    .enq_valid_i     (enq_valid_i),
    .enq_ready_o     (enq_ready_o),
    .deq_instr_o     (deq_instr_o),
    .deq_pc_o        (deq_pc_o),
    .deq_errtype_o   (deq_errtype_o),
    .deq_valid_o     (deq_valid_o),
    .deq_take_i      (deq_take_i),
    .count_o         (count_o),
    .empty_o         (empty_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;
  int n_step   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: queue of groups whose validword is the remaining mask.
  fetch_group_t q[$];
  lane_t        exp_lane [2];
  int           exp_n;

  task automatic model_lanes();
    fetch_group_t g;
    int w;
    exp_n = 0;
    if (q.size() == 0) return;
    g = q[0];
    if (g.errtype != 0) begin
      w = 0;
      for (int k = 3; k >= 0; k--) if (g.validword[k]) w = k;
      exp_lane[0].instr   = g.instr[32*w +: 32];
      exp_lane[0].pc      = g.grouppc + 64'(4 * w);
      exp_lane[0].errtype = g.errtype;
      exp_n = 1;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (g.validword[k] && exp_n < 2) begin
          exp_lane[exp_n].instr   = g.instr[32*k +: 32];
          exp_lane[exp_n].pc      = g.grouppc + 64'(4 * k);
          exp_lane[exp_n].errtype = '0;
          exp_n++;
        end
      end
    end
  endtask

  task automatic model_update(input logic ev, input fetch_group_t g, input int take, input logic fl);
    fetch_group_t h;
    int cnt0, left;
    if (fl) begin
      q.delete();
      return;
    end
    cnt0 = q.size();
    if (take > 0 && cnt0 > 0) begin
      h = q[0];
      if (h.errtype != 0) void'(q.pop_front());
      else begin
        left = take;
        for (int k = 0; k < 4; k++)
          if (h.validword[k] && left > 0) begin
            h.validword[k] = 1'b0;
            left--;
          end
        if (h.validword == 0) void'(q.pop_front());
        else q[0] = h;
      end
    end
    if (ev && cnt0 < 4 && !(g.validword == 0 && g.errtype == 0)) q.push_back(g);
  endtask

  task automatic check_outputs();
    logic [1:0] ev;
    model_lanes();
    check_eq("count", 64'(count_o), 64'(q.size()));
    check_eq("empty", 64'(empty_o), 64'(q.size() == 0));
    check_eq("ready", 64'(enq_ready_o), 64'(q.size() < 4));
    ev = 2'((1 << exp_n) - 1);
    check_eq("valid", 64'(deq_valid_o), 64'(ev));
    for (int l = 0; l < exp_n; l++) begin
      check_eq($sformatf("instr%0d", l), 64'(deq_instr_o[32*l +: 32]), 64'(exp_lane[l].instr));
      check_eq($sformatf("pc%0d", l), deq_pc_o[64*l +: 64], exp_lane[l].pc);
      check_eq($sformatf("err%0d", l), 64'(deq_errtype_o[6*l +: 6]), 64'(exp_lane[l].errtype));
    end
  endtask

  // Called at a falling edge: check, drive, clock, update model.
  task automatic step(input logic ev, input fetch_group_t g, input int take, input logic fl);
    check_outputs();
    if (take > exp_n) take = exp_n;
    enq_valid_i     = ev;
    enq_instr_i     = g.instr;
    enq_grouppc_i   = g.grouppc;
    enq_validword_i = g.validword;
    enq_errtype_i   = g.errtype;
    deq_take_i      = 2'(take);
    flush_i         = fl;
    n_step++;
    $display("step %0d: enq=%0b pc=0x%0h vw=%b err=0x%0h take=%0d flush=%0b count=%0d",
             n_step, ev, g.grouppc, g.validword, g.errtype, take, fl, count_o);
    @(posedge clk_i);
    model_update(ev, g, take, fl);
    @(negedge clk_i);
  endtask

  function automatic fetch_group_t mkg(input logic [63:0] pc, input logic [3:0] vw, input logic [5:0] err);
    fetch_group_t g;
    g.instr     = {$urandom, $urandom, $urandom, $urandom};
    g.grouppc   = pc;
    g.validword = vw;
    g.errtype   = err;
    return g;
  endfunction

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) step(1'b0, mkg(64'h0, 4'h0, 6'h0), 2, 1'b0);
    check_eq("drain_empty", 64'(empty_o), 64'h1);
  endtask

  fetch_group_t gg;

  initial begin
    arst_i = 1'b1; flush_i = 1'b0; enq_valid_i = 1'b0; deq_take_i = '0;
    enq_instr_i = '0; enq_grouppc_i = '0; enq_validword_i = '0; enq_errtype_i = '0;
    repeat (2) @(negedge clk_i);
    check_eq("rst_count", 64'(count_o), 64'h0);
    check_eq("rst_empty", 64'(empty_o), 64'h1);
    check_eq("rst_ready", 64'(enq_ready_o), 64'h1);
    check_eq("rst_valid", 64'(deq_valid_o), 64'h0);
    arst_i = 1'b0;

    // Full group, take 2 per cycle.
    step(1'b1, mkg(64'h1000, 4'b1111, 6'h0), 0, 1'b0);
    check_eq("g1_pc0", deq_pc_o[63:0], 64'h1000);
    check_eq("g1_pc1", deq_pc_o[127:64], 64'h1004);
    step(1'b0, mkg(64'h0, 4'h0, 6'h0), 2, 1'b0);
    check_eq("g1_pc2", deq_pc_o[63:0], 64'h1008);
    check_eq("g1_pc3", deq_pc_o[127:64], 64'h100C);
    step(1'b0, mkg(64'h0, 4'h0, 6'h0), 2, 1'b0);
    check_eq("g1_empty", 64'(empty_o), 64'h1);

    // Sparse mask, take 1.
    step(1'b1, mkg(64'h2000, 4'b1010, 6'h0), 0, 1'b0);
    check_eq("g2_valid", 64'(deq_valid_o), 64'h3);
    check_eq("g2_pc0", deq_pc_o[63:0], 64'h2004);
    step(1'b0, mkg(64'h0, 4'h0, 6'h0), 1, 1'b0);
    check_eq("g2_valid_b", 64'(deq_valid_o), 64'h1);
    check_eq("g2_pc0_b", deq_pc_o[63:0], 64'h200C);
    step(1'b0, mkg(64'h0, 4'h0, 6'h0), 1, 1'b0);
    check_eq("g2_empty", 64'(empty_o), 64'h1);

    // Fill to full, then pop while enqueueing.
    for (int i = 0; i < 4; i++) step(1'b1, mkg(64'h4000 + 64'(16*i), 4'b0011, 6'h0), 0, 1'b0);
    check_eq("full_count", 64'(count_o), 64'h4);
    check_eq("full_ready", 64'(enq_ready_o), 64'h0);
    step(1'b1, mkg(64'h5000, 4'b1111, 6'h0), 2, 1'b0);
    check_eq("full_blocked", 64'(count_o), 64'h3);
    step(1'b1, mkg(64'h5000, 4'b1111, 6'h0), 0, 1'b0);
    check_eq("full_refill", 64'(count_o), 64'h4);
    drain();

    // Faulting group.
    step(1'b1, mkg(64'h3000, 4'b0110, 6'h0C), 0, 1'b0);
    check_eq("flt_valid", 64'(deq_valid_o), 64'h1);
    check_eq("flt_pc", deq_pc_o[63:0], 64'h3004);
    check_eq("flt_err", 64'(deq_errtype_o[5:0]), 64'h0C);
    step(1'b0, mkg(64'h0, 4'h0, 6'h0), 1, 1'b0);
    check_eq("flt_empty", 64'(empty_o), 64'h1);

    // Flush beats enqueue and take.
    for (int i = 0; i < 3; i++) step(1'b1, mkg(64'h6000 + 64'(16*i), 4'b1111, 6'h0), 0, 1'b0);
    step(1'b1, mkg(64'h7000, 4'b1111, 6'h0), 2, 1'b1);
    check_eq("fl_count", 64'(count_o), 64'h0);
    check_eq("fl_valid", 64'(deq_valid_o), 64'h0);
    check_eq("fl_ready", 64'(enq_ready_o), 64'h1);

    // Empty group discarded; PC wrap.
    step(1'b1, mkg(64'h8000, 4'b0000, 6'h0), 0, 1'b0);
    check_eq("nil_empty", 64'(empty_o), 64'h1);
    step(1'b1, mkg(64'hFFFF_FFFF_FFFF_FFF8, 4'b1000, 6'h0), 0, 1'b0);
    check_eq("wrap_pc", deq_pc_o[63:0], 64'h4);
    drain();

    // Reset in the middle of traffic.
    step(1'b1, mkg(64'h9000, 4'b1111, 6'h0), 0, 1'b0);
    step(1'b1, mkg(64'h9010, 4'b1111, 6'h0), 1, 1'b0);
    arst_i = 1'b1;
    #1;
    check_eq("mid_rst_count", 64'(count_o), 64'h0);
    check_eq("mid_rst_valid", 64'(deq_valid_o), 64'h0);
    q.delete();
    @(negedge clk_i);
    arst_i = 1'b0;

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      gg = mkg(($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 : {$urandom, $urandom},
               4'($urandom), ($urandom_range(0, 5) == 0) ? 6'($urandom_range(1, 63)) : 6'h0);
      step(($urandom_range(0, 3) != 0), gg, $urandom_range(0, 2), ($urandom_range(0, 39) == 0));
    end
    check_outputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
